// File: rtl/mem_if_pkg.sv
// Shared definitions for the sort datapath's memory-side responder.
//
// Contents:
//   RESP_OKAY / RESP_SLVERR - write response codes carried on b_resp.
//   r_state_e               - read channel FSM states.
//   w_state_e               - write channel FSM states.
//   addr_in_range()         - unsigned bound check used by both the
//                             responder and the array, so the two cannot
//                             disagree on which addresses are implemented.
package mem_if_pkg;

    localparam int RESP_OKAY   = 0;
    localparam int RESP_SLVERR = 1;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_HAVE_A = 2'd1,
        W_HAVE_D = 2'd2,
        W_RESP   = 2'd3
    } w_state_e;

    // Out-of-range addresses never alias onto implemented words.
    function automatic logic addr_in_range(input int unsigned addr,
                                           input int unsigned size);
        return (addr < size);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Register array backing the memory responder.
//
// Ports:
//   clk                         - rising-edge clock.
//   axi_we/axi_addr/axi_wdata   - write port used by AXI write commits.
//   pl_we/pl_addr/pl_wdata      - side-band preload write port.
//   rd0_addr -> rd0_data        - combinational read (AR sample).
//   rd1_addr -> rd1_data        - combinational read (peek).
//
// Both write ports act on the same edge; on an address collision the AXI
// port wins. Out-of-range writes are dropped and out-of-range reads give 0.
// Contents are deliberately not reset.
module mem_array
    import mem_if_pkg::*;
#(
    parameter int          ADDR_WDTH = 4,
    parameter int          DATA_WDTH = 32,
    parameter int unsigned MEM_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 axi_we,
    input  logic [ADDR_WDTH-1:0] axi_addr,
    input  logic [DATA_WDTH-1:0] axi_wdata,
    input  logic                 pl_we,
    input  logic [ADDR_WDTH-1:0] pl_addr,
    input  logic [DATA_WDTH-1:0] pl_wdata,
    input  logic [ADDR_WDTH-1:0] rd0_addr,
    output logic [DATA_WDTH-1:0] rd0_data,
    input  logic [ADDR_WDTH-1:0] rd1_addr,
    output logic [DATA_WDTH-1:0] rd1_data
);

    logic [DATA_WDTH-1:0] mem_q [MEM_SIZE];
    logic [DATA_WDTH-1:0] mem_d [MEM_SIZE];

    always_comb begin
        mem_d = mem_q;
        // Preload first so a same-address AXI write overrides it.
        if (pl_we && addr_in_range(32'(pl_addr), MEM_SIZE)) begin
            mem_d[pl_addr] = pl_wdata;
        end
        if (axi_we && addr_in_range(32'(axi_addr), MEM_SIZE)) begin
            mem_d[axi_addr] = axi_wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rd0_data = '0;
        rd1_data = '0;
        if (addr_in_range(32'(rd0_addr), MEM_SIZE)) begin
            rd0_data = mem_q[rd0_addr];
        end
        if (addr_in_range(32'(rd1_addr), MEM_SIZE)) begin
            rd1_data = mem_q[rd1_addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the sort datapath's AXI-lite-style interface.
//
// Ports:
//   clk, rst                    - clock, synchronous active-high reset.
//   ar_* / r_*                  - read address / read data channels.
//   aw_* / w_* / b_*            - write address / data / response channels.
//   pl_we/pl_addr/pl_wdata      - side-band preload write.
//   pl_rdata                    - combinational peek of mem[pl_addr].
//   dbg_r_state / dbg_w_state   - current read / write FSM state.
//
// Handshake rule for every channel: a transfer happens on a rising edge
// where valid && ready are both high. ar/aw/w ready are registered outputs.
// r_valid/b_valid and their payloads hold until the matching ready is seen.
// Only one read and one write are ever outstanding; the two channels are
// independent of each other.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int          ADDR_WDTH = 4,
    parameter int          DATA_WDTH = 32,
    parameter int          RESP_WDTH = 1,
    parameter int unsigned MEM_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ar_valid,
    input  logic [ADDR_WDTH-1:0] ar_addr,
    output logic                 ar_ready,
    output logic                 r_valid,
    output logic [DATA_WDTH-1:0] r_data,
    input  logic                 r_ready,
    input  logic                 aw_valid,
    input  logic [ADDR_WDTH-1:0] aw_addr,
    output logic                 aw_ready,
    input  logic                 w_valid,
    input  logic [DATA_WDTH-1:0] w_data,
    output logic                 w_ready,
    output logic                 b_valid,
    output logic [RESP_WDTH-1:0] b_resp,
    input  logic                 b_ready,
    input  logic                 pl_we,
    input  logic [ADDR_WDTH-1:0] pl_addr,
    input  logic [DATA_WDTH-1:0] pl_wdata,
    output logic [DATA_WDTH-1:0] pl_rdata,
    output r_state_e             dbg_r_state,
    output w_state_e             dbg_w_state
);

    // ---------------- read channel ----------------
    r_state_e             r_state_q, r_state_d;
    logic                 r_valid_q, r_valid_d;
    logic [DATA_WDTH-1:0] r_data_q, r_data_d;
    logic                 ar_ready_q, ar_ready_d;
    logic [DATA_WDTH-1:0] rd_sample;
    logic                 ar_hs;

    // ---------------- write channel ----------------
    w_state_e             w_state_q, w_state_d;
    logic [ADDR_WDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WDTH-1:0] w_data_q, w_data_d;
    logic                 aw_ready_q, aw_ready_d;
    logic                 w_ready_q, w_ready_d;
    logic                 b_valid_q, b_valid_d;
    logic [RESP_WDTH-1:0] b_resp_q, b_resp_d;
    logic                 aw_hs, w_hs;

    // Commit request: the moment both halves of a write are known.
    logic                 cmt;
    logic [ADDR_WDTH-1:0] cmt_addr;
    logic [DATA_WDTH-1:0] cmt_data;
    logic                 cmt_ok;
    logic                 axi_we;

    assign ar_hs = ar_valid && ar_ready_q;
    assign aw_hs = aw_valid && aw_ready_q;
    assign w_hs  = w_valid  && w_ready_q;

    // The AR sample reads the pre-edge array, so a write committing on the
    // same edge is not visible to it.
    mem_array #(
        .ADDR_WDTH (ADDR_WDTH),
        .DATA_WDTH (DATA_WDTH),
        .MEM_SIZE  (MEM_SIZE)
    ) u_mem_array (
        .clk       (clk),
        .axi_we    (axi_we),
        .axi_addr  (cmt_addr),
        .axi_wdata (cmt_data),
        .pl_we     (pl_we),
        .pl_addr   (pl_addr),
        .pl_wdata  (pl_wdata),
        .rd0_addr  (ar_addr),
        .rd0_data  (rd_sample),
        .rd1_addr  (pl_addr),
        .rd1_data  (pl_rdata)
    );

    // Read FSM next state / outputs.
    always_comb begin
        r_state_d  = r_state_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        ar_ready_d = ar_ready_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_data_d   = rd_sample;
                    r_valid_d  = 1'b1;
                    ar_ready_d = 1'b0;
                    r_state_d  = R_RESP;
                end
            end
            R_RESP: begin
                if (r_ready) begin
                    r_valid_d  = 1'b0;
                    ar_ready_d = 1'b1;
                    r_state_d  = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write FSM next state / outputs.
    always_comb begin
        w_state_d  = w_state_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        cmt        = 1'b0;
        cmt_addr   = aw_addr_q;
        cmt_data   = w_data_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    cmt      = 1'b1;
                    cmt_addr = aw_addr;
                    cmt_data = w_data;
                end else if (aw_hs) begin
                    aw_addr_d  = aw_addr;
                    aw_ready_d = 1'b0;
                    w_state_d  = W_HAVE_A;
                end else if (w_hs) begin
                    w_data_d  = w_data;
                    w_ready_d = 1'b0;
                    w_state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                if (w_hs) begin
                    cmt      = 1'b1;
                    cmt_addr = aw_addr_q;
                    cmt_data = w_data;
                end
            end
            W_HAVE_D: begin
                if (aw_hs) begin
                    cmt      = 1'b1;
                    cmt_addr = aw_addr;
                    cmt_data = w_data_q;
                end
            end
            W_RESP: begin
                if (b_ready) begin
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                    w_ready_d  = 1'b1;
                    w_state_d  = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        if (cmt) begin
            b_resp_d   = cmt_ok ? RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_SLVERR);
            b_valid_d  = 1'b1;
            aw_ready_d = 1'b0;
            w_ready_d  = 1'b0;
            w_state_d  = W_RESP;
        end
    end

    assign cmt_ok = addr_in_range(32'(cmt_addr), MEM_SIZE);
    // A handshake landing on a reset edge is aborted, so it must not write.
    assign axi_we = cmt && cmt_ok && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= R_IDLE;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            ar_ready_q <= 1'b1;
            w_state_q  <= W_IDLE;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            b_valid_q  <= 1'b0;
            b_resp_q   <= '0;
        end else begin
            r_state_q  <= r_state_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            ar_ready_q <= ar_ready_d;
            w_state_q  <= w_state_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
        end
    end

    assign ar_ready    = ar_ready_q;
    assign r_valid     = r_valid_q;
    assign r_data      = r_data_q;
    assign aw_ready    = aw_ready_q;
    assign w_ready     = w_ready_q;
    assign b_valid     = b_valid_q;
    assign b_resp      = b_resp_q;
    assign dbg_r_state = r_state_q;
    assign dbg_w_state = w_state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (MEM_SIZE=10 so addresses 10..15 are
// out of range). A transaction-level model tracks what has been captured
// and what responses are owed; a compare process checks the DUT against it
// on every falling edge, and literal checks pin key values by hand.
module tb_mem_responder;
    import mem_if_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int MS = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ar_valid = 1'b0;
    logic [AW-1:0] ar_addr = '0;
    logic          ar_ready;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_ready = 1'b0;
    logic          aw_valid = 1'b0;
    logic [AW-1:0] aw_addr = '0;
    logic          aw_ready;
    logic          w_valid = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          w_ready;
    logic          b_valid;
    logic [0:0]    b_resp;
    logic          b_ready = 1'b0;
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_wdata = '0;
    logic [DW-1:0] pl_rdata;
    r_state_e      dbg_r_state;
    w_state_e      dbg_w_state;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    mem_responder #(
        .ADDR_WDTH (AW),
        .DATA_WDTH (DW),
        .RESP_WDTH (1),
        .MEM_SIZE  (MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ar_valid    (ar_valid),
        .ar_addr     (ar_addr),
        .ar_ready    (ar_ready),
        .r_valid     (r_valid),
        .r_data      (r_data),
        .r_ready     (r_ready),
        .aw_valid    (aw_valid),
        .aw_addr     (aw_addr),
        .aw_ready    (aw_ready),
        .w_valid     (w_valid),
        .w_data      (w_data),
        .w_ready     (w_ready),
        .b_valid     (b_valid),
        .b_resp      (b_resp),
        .b_ready     (b_ready),
        .pl_we       (pl_we),
        .pl_addr     (pl_addr),
        .pl_wdata    (pl_wdata),
        .pl_rdata    (pl_rdata),
        .dbg_r_state (dbg_r_state),
        .dbg_w_state (dbg_w_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [DW-1:0] m [16];
    logic          e_rbusy = 1'b0;
    logic [DW-1:0] e_rdata = '0;
    logic          e_have_a = 1'b0;
    logic          e_have_d = 1'b0;
    logic [AW-1:0] e_a = '0;
    logic [DW-1:0] e_d = '0;
    logic          e_bbusy = 1'b0;
    logic          e_bresp = 1'b0;

    function automatic logic [DW-1:0] model_peek(input logic [AW-1:0] a);
        return (int'(a) < MS) ? m[a] : '0;
    endfunction

    always @(posedge clk) begin
        logic [DW-1:0] old_rd;
        logic ar_fire, aw_fire, w_fire;
        old_rd  = model_peek(ar_addr);
        ar_fire = ar_valid && !e_rbusy;
        aw_fire = aw_valid && !e_have_a && !e_bbusy;
        w_fire  = w_valid  && !e_have_d && !e_bbusy;
        if (pl_we && int'(pl_addr) < MS) m[pl_addr] = pl_wdata;
        if (rst) begin
            e_rbusy = 1'b0; e_rdata = '0;
            e_have_a = 1'b0; e_have_d = 1'b0;
            e_bbusy = 1'b0; e_bresp = 1'b0;
        end else begin
            if (e_rbusy) begin
                if (r_ready) e_rbusy = 1'b0;
            end else if (ar_fire) begin
                e_rbusy = 1'b1;
                e_rdata = old_rd;
            end
            if (e_bbusy) begin
                if (b_ready) e_bbusy = 1'b0;
            end else begin
                if (aw_fire) begin e_have_a = 1'b1; e_a = aw_addr; end
                if (w_fire)  begin e_have_d = 1'b1; e_d = w_data;  end
                if (e_have_a && e_have_d) begin
                    if (int'(e_a) < MS) begin
                        m[e_a] = e_d;
                        e_bresp = 1'b0;
                    end else begin
                        e_bresp = 1'b1;
                    end
                    e_bbusy = 1'b1;
                    e_have_a = 1'b0;
                    e_have_d = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ar_ready", 32'(ar_ready), 32'(!e_rbusy));
            check("r_valid",  32'(r_valid),  32'(e_rbusy));
            check("aw_ready", 32'(aw_ready), 32'(!e_have_a && !e_bbusy));
            check("w_ready",  32'(w_ready),  32'(!e_have_d && !e_bbusy));
            check("b_valid",  32'(b_valid),  32'(e_bbusy));
            if (e_rbusy) check("r_data", r_data, e_rdata);
            if (e_bbusy) check("b_resp", 32'(b_resp), 32'(e_bresp));
            check("pl_rdata", pl_rdata, model_peek(pl_addr));
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_we = 1'b1; pl_addr = a; pl_wdata = d;
        tick();
        pl_we = 1'b0;
    endtask

    // Single-edge read and write with both ready lines high.
    task automatic rw_same_edge(input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd);
        r_ready = 1'b1; b_ready = 1'b1;
        ar_valid = 1'b1; ar_addr = ra;
        aw_valid = 1'b1; aw_addr = wa;
        w_valid = 1'b1;  w_data = wd;
        tick();
        ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
    endtask

    initial begin
        // Reset then idle.
        rst = 1'b1;
        tick(); tick();
        check("rst_ar_ready", 32'(ar_ready), 32'd1);
        check("rst_aw_ready", 32'(aw_ready), 32'd1);
        check("rst_w_ready",  32'(w_ready),  32'd1);
        check("rst_r_valid",  32'(r_valid),  32'd0);
        check("rst_b_valid",  32'(b_valid),  32'd0);
        check("rst_b_resp",   32'(b_resp),   32'd0);
        check("rst_r_data",   r_data,        32'd0);
        rst = 1'b0;

        // Known array contents; the write to 12 must be ignored.
        for (int i = 0; i < MS; i++) preload(AW'(i), 32'h1000 + i);
        preload(4'd12, 32'hBAD0BAD0);
        chk_en = 1'b1;
        pl_addr = 4'd12; #1;
        check("peek_oor", pl_rdata, 32'd0);

        // Preload then read.
        preload(4'd3, 32'hDEADBEEF);
        r_ready = 1'b1; ar_valid = 1'b1; ar_addr = 4'd3;
        tick();
        ar_valid = 1'b0;
        check("rd3_valid", 32'(r_valid), 32'd1);
        check("rd3_data",  r_data, 32'hDEADBEEF);
        check("rd3_arrdy", 32'(ar_ready), 32'd0);
        tick();
        check("rd3_done", 32'(r_valid), 32'd0);

        // W one cycle before AW.
        b_ready = 1'b1;
        w_valid = 1'b1; w_data = 32'h11;
        tick();
        w_valid = 1'b0;
        check("wfirst_wrdy", 32'(w_ready), 32'd0);
        aw_valid = 1'b1; aw_addr = 4'd5;
        tick();
        aw_valid = 1'b0;
        pl_addr = 4'd5; #1;
        check("wfirst_bvalid", 32'(b_valid), 32'd1);
        check("wfirst_bresp",  32'(b_resp),  32'd0);
        check("wfirst_peek",   pl_rdata, 32'h11);
        tick();

        // AW one cycle before W.
        aw_valid = 1'b1; aw_addr = 4'd6;
        tick();
        aw_valid = 1'b0;
        check("afirst_awrdy", 32'(aw_ready), 32'd0);
        w_valid = 1'b1; w_data = 32'h22;
        tick();
        w_valid = 1'b0;
        pl_addr = 4'd6; #1;
        check("afirst_bvalid", 32'(b_valid), 32'd1);
        check("afirst_peek",   pl_rdata, 32'h22);
        tick();

        // AW and W on the same edge.
        aw_valid = 1'b1; aw_addr = 4'd4; w_valid = 1'b1; w_data = 32'h33;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        pl_addr = 4'd4; #1;
        check("both_bvalid", 32'(b_valid), 32'd1);
        check("both_peek",   pl_rdata, 32'h33);
        tick();

        // Backpressure: hold both responses for 4 cycles while new
        // requests wait on the channels.
        r_ready = 1'b0; b_ready = 1'b0;
        ar_valid = 1'b1; ar_addr = 4'd1;
        aw_valid = 1'b1; aw_addr = 4'd2; w_valid = 1'b1; w_data = 32'h44;
        tick();
        ar_addr = 4'd8; aw_addr = 4'd9; w_data = 32'h77;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_r_data", r_data, 32'h1001);
            check("bp_b_resp", 32'(b_resp), 32'd0);
            check("bp_readies", {29'd0, ar_ready, aw_ready, w_ready}, 32'd0);
        end
        ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
        r_ready = 1'b1; b_ready = 1'b1;
        tick();
        pl_addr = 4'd9; #1;
        check("bp_no_write9", pl_rdata, 32'h1009);

        // Out of range write and read; boundary read of the last word.
        rw_same_edge(4'd12, 4'd12, 32'h55);
        check("oor_bresp", 32'(b_resp), 32'd1);
        check("oor_rdata", r_data, 32'd0);
        tick();
        rw_same_edge(4'd9, 4'd10, 32'h66);
        check("last_rdata", r_data, 32'h1009);
        check("b10_bresp",  32'(b_resp), 32'd1);
        tick();

        // Same-address read and write commit: read sees the old value.
        preload(4'd7, 32'h1);
        rw_same_edge(4'd7, 4'd7, 32'h2);
        pl_addr = 4'd7; #1;
        check("coll_rdata", r_data, 32'h1);
        check("coll_peek",  pl_rdata, 32'h2);
        tick();

        // Preload and AXI write to the same word on one edge: AXI wins.
        pl_we = 1'b1; pl_addr = 4'd8; pl_wdata = 32'hAA;
        aw_valid = 1'b1; aw_addr = 4'd8; w_valid = 1'b1; w_data = 32'hBB;
        tick();
        pl_we = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
        check("pl_vs_axi", pl_rdata, 32'hBB);
        tick();

        // Reset while only AW is captured: nothing is written or answered.
        aw_valid = 1'b1; aw_addr = 4'd0;
        tick();
        aw_valid = 1'b0;
        check("hava_awrdy", 32'(aw_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rsta_awrdy", 32'(aw_ready), 32'd1);
        check("rsta_bvalid", 32'(b_valid), 32'd0);
        w_valid = 1'b1; w_data = 32'h99;
        tick();
        w_valid = 1'b0;
        pl_addr = 4'd0; #1;
        check("rsta_nobvalid", 32'(b_valid), 32'd0);
        check("rsta_peek0", pl_rdata, 32'h1000);
        aw_valid = 1'b1; aw_addr = 4'd1;
        tick();
        aw_valid = 1'b0;
        pl_addr = 4'd1; #1;
        check("rsta_commit1", pl_rdata, 32'h99);
        tick(); tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the sort datapath's simplified AXI-lite-style memory interface: accepts AR/R read transactions and AW/W/B write transactions from the sort controller/datapath.
- Backs the transactions with an internal register array of MEM_SIZE words.
- Also has a side-band preload/peek port so the bench or top-level can fill the array before a sort and inspect it afterwards.
- Sits opposite the sort controller at the top level and replaces an external memory model.

Parameters:
- ADDR_WDTH, 4: address width in words.
- DATA_WDTH, 32: data word width.
- RESP_WDTH, 1: write response width.
- MEM_SIZE, 16: number of implemented words; must be <= 2**ADDR_WDTH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ar_valid  in  1  read address valid.
- ar_addr  in  ADDR_WDTH  read address.
- ar_ready  out  1  read address accepted.
- r_valid  out  1  read data valid.
- r_data  out  DATA_WDTH  read data.
- r_ready  in  1  read data taken.
- aw_valid  in  1  write address valid.
- aw_addr  in  ADDR_WDTH  write address.
- aw_ready  out  1  write address accepted.
- w_valid  in  1  write data valid.
- w_data  in  DATA_WDTH  write data.
- w_ready  out  1  write data accepted.
- b_valid  out  1  write response valid.
- b_resp  out  RESP_WDTH  0 = OKAY, 1 = SLVERR.
- b_ready  in  1  write response taken.
- pl_we  in  1  preload write enable.
- pl_addr  in  ADDR_WDTH  preload/peek address.
- pl_wdata  in  DATA_WDTH  preload data.
- pl_rdata  out  DATA_WDTH  combinational peek of mem[pl_addr]; 0 if pl_addr >= MEM_SIZE.

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid && ready are both high.
- Once asserted, r_valid and b_valid, and their payloads, hold until the corresponding ready is seen.
- Reset: while rst is high at an edge, read FSM -> R_IDLE, write FSM -> W_IDLE, r_valid=0, b_valid=0, r_data=0, b_resp=0.
  - After reset, ar_ready, aw_ready and w_ready are 1 (registered).
  - Array contents are not reset.
  - Reset mid-transaction aborts it. A write whose AW and W were both captured before the reset edge has already committed; a half-captured write is dropped.
- Read FSM, R_IDLE and R_RESP:
  - R_IDLE: ar_ready=1. An AR handshake samples mem[ar_addr] (value before any write committing on the same edge) into r_data, or 0 if ar_addr >= MEM_SIZE. Then r_valid=1, ar_ready=0, go to R_RESP.
  - R_RESP: when r_ready=1, r_valid=0, ar_ready=1, return to R_IDLE.
  - Latency: r_valid rises the cycle after the AR handshake. Maximum throughput is one read per 2 cycles. Only one read is outstanding.
- Write FSM, W_IDLE, W_HAVE_A, W_HAVE_D and W_RESP:
  - AW and W are captured independently, in either order or on the same edge.
  - W_IDLE: aw_ready=w_ready=1.
    - AW only -> W_HAVE_A, aw_ready=0.
    - W only -> W_HAVE_D, w_ready=0.
    - Both on the same edge -> commit immediately.
  - W_HAVE_A: a W handshake commits. W_HAVE_D: an AW handshake commits.
  - Commit:
    - If addr < MEM_SIZE, mem[addr] <= data on that edge, b_resp=0.
    - Otherwise there is no write and b_resp=1.
    - Then b_valid=1, aw_ready=w_ready=0, go to W_RESP.
  - W_RESP: when b_ready=1, b_valid=0, aw_ready=w_ready=1, return to W_IDLE.
  - Latency: b_valid rises the cycle after the last of AW/W is captured.
- Read and write channels are fully independent and may be active concurrently.
- Same-address read and write commit on one edge: read returns the old data.
- Preload:
  - pl_we=1 writes mem[pl_addr] <= pl_wdata if pl_addr < MEM_SIZE; otherwise it is ignored.
  - If a preload and an AXI write commit hit the same address on the same edge, the AXI write wins.
  - Preload does not affect the handshake FSMs.
- Addresses are compared unsigned. There is no wrap-around; out-of-range addresses never alias.

Decomposition:
- Shared package mem_if_pkg holds:
  - RESP_OKAY=0 and RESP_SLVERR=1.
  - Read FSM state encoding (R_IDLE, R_RESP).
  - Write FSM state encoding (W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP).
- One sub-module, mem_array:
  - MEM_SIZE x DATA_WDTH registers.
  - Two synchronous write ports, AXI port priority over preload port.
  - Two combinational read ports, for the AR sample and the peek.
- Handshake FSMs live in mem_responder.

Test Plan:
- Reset then idle: hold rst 2 cycles -> ar_ready=aw_ready=w_ready=1, r_valid=b_valid=0, b_resp=0.
- Preload then read: pl_we addr 3 = 0xDEADBEEF; AR addr 3 with r_ready=1 -> r_valid=1 next cycle, r_data=0xDEADBEEF, ar_ready=0 during R_RESP.
- Write order variants: W (0x11) one cycle before AW (addr 5) -> b_valid next cycle after AW, b_resp=0, pl_rdata@5=0x11. Repeat with AW first and with both on the same edge.
- Backpressure: hold r_ready=0 and b_ready=0 for 4 cycles -> r_valid/r_data and b_valid/b_resp stable; ar_ready, aw_ready and w_ready stay 0.
- Out of range (MEM_SIZE=10): write addr 12 -> b_resp=1, array unchanged; read addr 12 -> r_data=0.
- Collisions:
  - Read and write addr 7 on the same edge, old 0x1, new 0x2 -> r_data=0x1, later peek=0x2.
  - Assert rst while in W_HAVE_A -> returns to W_IDLE, no write, no b_valid.
